cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter BEAT_W, 64, width of one memory-bus beat in bits.
REQ-002 Parameter BEATS, 4, beats per 256-bit line; BEAT_W*BEATS SHALL equal 256.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 line_address  input  32  line request address from the L2 cache miss path.
REQ-006 line_read  input  1  line fill request.
REQ-007 line_write  input  1  line writeback request.
REQ-008 line_wdata  input  256  line to write back.
REQ-009 line_rdata  output  256  assembled fill line.
REQ-010 line_resp  output  1  one-cycle completion pulse.
REQ-011 burst_address  output  32  line-aligned memory address.
REQ-012 burst_read  output  1  memory read burst request.
REQ-013 burst_write  output  1  memory write burst request.
REQ-014 burst_wdata  output  BEAT_W  current write beat.
REQ-015 burst_rdata  input  BEAT_W  current read beat.
REQ-016 burst_resp  input  1  memory accepted or delivered one beat this cycle.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, READ, WRITE, READ_DONE, WRITE_DONE.
REQ-018 In IDLE, line_write=1 SHALL move to WRITE; otherwise line_read=1 SHALL move to READ; write wins when both are high.
REQ-019 On leaving IDLE, the block SHALL latch {line_address[31:5],5'b0} into burst_address, latch line_wdata (writes only), and clear the 2-bit beat counter.
REQ-020 burst_address SHALL hold its latched value until the next IDLE exit.
REQ-021 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE.
REQ-022 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line_rdata[BEAT_W*k +: BEAT_W], where k is the beat counter, then increment k.
REQ-023 In WRITE, burst_wdata SHALL equal latched_wdata[BEAT_W*k +: BEAT_W]; each burst_resp=1 SHALL increment k.
REQ-024 burst_resp=0 SHALL stall the counter and the outputs with no timeout.
REQ-025 A burst_resp on beat k=BEATS-1 SHALL move READ to READ_DONE or WRITE to WRITE_DONE, and SHALL deassert burst_read/burst_write on the next cycle.
REQ-026 READ_DONE and WRITE_DONE SHALL each last one cycle with line_resp=1, then return to IDLE.
REQ-027 Latency SHALL be (cycles to 4 beats) + 1 from the first request cycle to line_resp.
REQ-028 line_rdata SHALL hold its value after READ_DONE until beat 0 of the next read overwrites it.
REQ-029 line_read/line_write changes outside IDLE SHALL be ignored.
REQ-030 burst_resp in IDLE or a DONE state SHALL be ignored.
REQ-031 Requests still high in IDLE after line_resp SHALL start a new transaction; the caller deasserts them on line_resp.
REQ-032 Counter wrap from 3 to 0 SHALL occur only together with the DONE transition.

Reset
REQ-033 rst=1 SHALL force IDLE, k=0, and line_resp, burst_read, burst_write = 0, at any time including mid-burst.
REQ-034 rst=1 SHALL force burst_address, burst_wdata, line_rdata and the latched write line to 0.
REQ-035 After reset deassertion, no burst SHALL resume.

Structure
REQ-036 A shared package SHALL hold the state enum and the BEAT_W, BEATS and line-width constants, for reuse by the L2 controller.
REQ-037 One sub-module, cacheline_buffer, SHALL implement the 256-bit register with beat-indexed write and read; the FSM and counter SHALL live in cacheline_adaptor.

Verification
REQ-038 Read, no stalls:
- line_read at 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
- Required: burst_address=0x0000_1220; line_rdata={0x44..,0x33..,0x22..,0x11..}; line_resp one cycle after beat 4.
REQ-039 Write with stalls:
- line_write with line_wdata=0xA..A_B..B_C..C_D..D; burst_resp low 2 cycles before each beat.
- Required: burst_wdata sequence D,C,B,A; burst_write high 12 cycles; line_resp single pulse.
REQ-040 Simultaneous line_read and line_write in IDLE -> WRITE burst first; burst_read never asserted.
REQ-041 rst asserted after beat 2 of a read -> outputs 0 immediately (asynchronous); no line_resp; a later read completes normally.
REQ-042 Stray burst_resp pulses in IDLE -> no state change, counter stays 0, line_rdata unchanged.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and FSM state type for the L2 line <-> memory-burst adaptor.
// The L2 controller reuses these to size its line datapath.
package cacheline_adaptor_pkg;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        READ_DONE,
        WRITE_DONE
    } state_e;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Line-side request/response and memory-side burst signals of the adaptor.
interface cacheline_adaptor_if #(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
);
    import cacheline_adaptor_pkg::*;

    logic [ADDR_W-1:0] line_address;
    logic              line_read;
    logic              line_write;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;
    logic [ADDR_W-1:0] burst_address;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    // slave: the adaptor; master: the cache and memory around it
    modport slave (
        input  line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        output line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
    );
    modport master (
        output line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        input  line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/cacheline_buffer.sv
// Line register with whole-line load, beat-indexed write and beat-indexed read.
module cacheline_buffer #(
    parameter  int BEAT_W = 64,
    parameter  int BEATS  = 4,
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BEATS*BEAT_W-1:0] load_data,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [BEAT_W-1:0]       wdata,
    output logic [BEAT_W-1:0]       rdata,
    output logic [BEATS*BEAT_W-1:0] line
);
    logic [BEATS-1:0][BEAT_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       mem <= '0;
        else if (load) mem <= load_data;
        else if (we)   mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
    assign line  = mem;
endmodule

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line fills/writebacks into BEATS-beat memory bursts.
// Burst control outputs and line_resp are registered straight out of the FSM.
module cacheline_adaptor #(
    parameter int BEAT_W = cacheline_adaptor_pkg::BEAT_W,
    parameter int BEATS  = cacheline_adaptor_pkg::BEATS
) (
    input logic               clk,
    input logic               rst,
    cacheline_adaptor_if.slave bus
);
    import cacheline_adaptor_pkg::*;

    localparam int               IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(BEATS - 1);

    state_e            state;
    logic [IDX_W-1:0]  k;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q, resp_q;
    logic              rd_beat_we, wr_load;

    logic [BEAT_W-1:0]       unused_rd_beat;
    logic [BEATS*BEAT_W-1:0] unused_wr_line;

    assign rd_beat_we = (state == READ) && bus.burst_resp;
    assign wr_load    = (state == IDLE) && bus.line_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            resp_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q <= 1'b0;
                    // write has priority when both requests arrive together
                    if (bus.line_write) begin
                        state  <= WRITE;
                        wr_q   <= 1'b1;
                        k      <= '0;
                        addr_q <= {bus.line_address[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end else if (bus.line_read) begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        k      <= '0;
                        addr_q <= {bus.line_address[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end
                end
                READ: if (bus.burst_resp) begin
                    k <= k + 1'b1;
                    if (k == LAST) begin
                        state  <= READ_DONE;
                        rd_q   <= 1'b0;
                        resp_q <= 1'b1;
                    end
                end
                WRITE: if (bus.burst_resp) begin
                    k <= k + 1'b1;
                    if (k == LAST) begin
                        state  <= WRITE_DONE;
                        wr_q   <= 1'b0;
                        resp_q <= 1'b1;
                    end
                end
                READ_DONE, WRITE_DONE: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    resp_q <= 1'b0;
                end
            endcase
        end
    end

    // Fill line: assembled beat by beat, holds until the next read overwrites it
    cacheline_buffer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .we        (rd_beat_we),
        .idx       (k),
        .wdata     (bus.burst_rdata),
        .rdata     (unused_rd_beat),
        .line      (bus.line_rdata)
    );

    // Writeback line: captured on IDLE exit, streamed out beat by beat
    cacheline_buffer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_wr_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_load),
        .load_data (bus.line_wdata),
        .we        (1'b0),
        .idx       (k),
        .wdata     ('0),
        .rdata     (bus.burst_wdata),
        .line      (unused_wr_line)
    );

    assign bus.burst_address = addr_q;
    assign bus.burst_read    = rd_q;
    assign bus.burst_write   = wr_q;
    assign bus.line_resp     = resp_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: table of line transactions plus reset/stray-resp sequences.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adaptor_if #(.BEAT_W(64), .LINE_W(256)) bus ();

    cacheline_adaptor #(.BEAT_W(64), .BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] mem;       // beats memory returns on a read
        int           stall;     // idle cycles before each beat
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata; // line_rdata expected at line_resp
        int           exp_lat;
        int           exp_busy;
    } vec_t;

    vec_t vecs[4];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int   beat = 0;
        int   st   = 0;
        int   cyc  = 0;
        int   rd_hi = 0;
        int   wr_hi = 0;
        logic done = 1'b0;
        logic resp;
        logic [255:0] v_mem;
        logic [255:0] v_wd;
        v_mem = v.mem;
        v_wd  = v.wdata;
        bus.line_address = v.addr;
        bus.line_read    = v.rd;
        bus.line_write   = v.wr;
        bus.line_wdata   = v.wdata;
        bus.burst_resp   = 1'b0;
        @(negedge clk);
        cyc = 1;
        check({tag, " burst_address"}, 256'(bus.burst_address), 256'(v.exp_addr));
        while (!done && cyc < 100) begin
            if (bus.line_resp) begin
                done = 1'b1;
            end else begin
                if (bus.burst_read)  rd_hi++;
                if (bus.burst_write) wr_hi++;
                if (st == v.stall) begin resp = 1'b1; st = 0; end
                else begin resp = 1'b0; st++; end
                if (resp && v.wr)
                    check({tag, " burst_wdata"}, 256'(bus.burst_wdata), 256'(v_wd[64*(beat%4) +: 64]));
                bus.burst_rdata = v_mem[64*(beat%4) +: 64];
                bus.burst_resp  = resp;
                if (resp) beat++;
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " completed"}, 256'(done), 256'(1));
        check({tag, " latency"}, 256'(cyc), 256'(v.exp_lat));
        check({tag, " burst_read cycles"}, 256'(rd_hi), 256'(v.wr ? 0 : v.exp_busy));
        check({tag, " burst_write cycles"}, 256'(wr_hi), 256'(v.wr ? v.exp_busy : 0));
        check({tag, " ctrl low in done"}, 256'({bus.burst_read, bus.burst_write}), 256'(0));
        check({tag, " line_rdata"}, bus.line_rdata, v.exp_rdata);
        // caller drops the request on line_resp; stray beat in the DONE state
        bus.line_read   = 1'b0;
        bus.line_write  = 1'b0;
        bus.burst_rdata = 64'hFFFF_0000_FFFF_0000;
        bus.burst_resp  = 1'b1;
        @(negedge clk);
        bus.burst_resp = 1'b0;
        check({tag, " resp single pulse"}, 256'(bus.line_resp), 256'(0));
        check({tag, " idle after done"}, 256'({bus.burst_read, bus.burst_write}), 256'(0));
        check({tag, " line_rdata held"}, bus.line_rdata, v.exp_rdata);
    endtask

    initial begin
        logic [255:0] l0, w1, w2, l3;
        l0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        w1 = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        w2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};
        l3 = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
              64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};

        vecs[0] = '{rd:1'b1, wr:1'b0, addr:32'h0000_1234, wdata:'0, mem:l0, stall:0,
                    exp_addr:32'h0000_1220, exp_rdata:l0, exp_lat:5, exp_busy:4};
        vecs[1] = '{rd:1'b0, wr:1'b1, addr:32'h0000_ABCD, wdata:w1, mem:'0, stall:2,
                    exp_addr:32'h0000_ABC0, exp_rdata:l0, exp_lat:13, exp_busy:12};
        vecs[2] = '{rd:1'b1, wr:1'b1, addr:32'hFFFF_FFFF, wdata:w2, mem:l3, stall:1,
                    exp_addr:32'hFFFF_FFE0, exp_rdata:l0, exp_lat:9, exp_busy:8};
        vecs[3] = '{rd:1'b1, wr:1'b0, addr:32'h8000_001F, wdata:'0, mem:l3, stall:1,
                    exp_addr:32'h8000_0000, exp_rdata:l3, exp_lat:9, exp_busy:8};

        rst = 1'b1;
        bus.line_address = '0;
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ctrl", 256'({bus.line_resp, bus.burst_read, bus.burst_write}), 256'(0));
        check("reset burst_address", 256'(bus.burst_address), 256'(0));
        check("reset burst_wdata", 256'(bus.burst_wdata), 256'(0));
        check("reset line_rdata", bus.line_rdata, 256'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run(vecs[i], $sformatf("vec%0d", i));

        // stray beats while idle must not move the FSM or touch the fill line
        bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.burst_resp  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray idle ctrl", 256'({bus.line_resp, bus.burst_read, bus.burst_write}), 256'(0));
        end
        bus.burst_resp = 1'b0;
        check("stray idle line_rdata", bus.line_rdata, l3);
        run(vecs[0], "after stray");

        // reset in the middle of a read, after two beats
        bus.line_address = 32'h0000_1234;
        bus.line_read    = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            bus.burst_rdata = l0[64*b +: 64];
            bus.burst_resp  = 1'b1;
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        bus.line_read  = 1'b0;
        check("mid-read burst_read", 256'(bus.burst_read), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("async rst ctrl", 256'({bus.line_resp, bus.burst_read, bus.burst_write}), 256'(0));
        check("async rst burst_address", 256'(bus.burst_address), 256'(0));
        check("async rst line_rdata", bus.line_rdata, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no resume after rst", 256'({bus.line_resp, bus.burst_read, bus.burst_write}), 256'(0));
        end
        run(vecs[3], "post-reset read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
